// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment capture path: glyph table,
// slot count and the per-slot record held between anode visits.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment order {a,b,c,d,e,f,g}, active-low, identical to the display encoder.
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Element i holds the glyph for hex value i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef logic [1:0] slot_t;
  typedef logic [3:0] hex_t;

  typedef struct packed {
    hex_t hex;
    logic dp;
    logic err;
  } slot_rec_t;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational glyph-to-hex decoder; any pattern outside the table reads as
// hex 0 with the error flag set.
module sseg_decoder
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       err
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hex = '0;
    err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i]) begin
        hex = hex_t'(i);
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sseg_capture.sv
// Receiver for a scanned seven-segment bus: synchronizes an/seg, latches each
// stable anode visit once, and publishes a coherent four-digit frame.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_tick
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]            an_meta, an_sync, an_prev;
  logic [7:0]            seg_meta, seg_sync, seg_prev;
  logic [CNT_W-1:0]      stab_cnt;
  logic                  visited;
  logic [NUM_DIGITS-1:0] seen;
  logic                  frame_pend;
  logic [TIMEOUT_W-1:0]  tmo_cnt;
  slot_rec_t             shadow [NUM_DIGITS];

  logic                  bus_stable;
  logic                  an_changed;
  logic                  slot_valid;
  slot_t                 slot_idx;
  logic                  do_latch;
  logic [NUM_DIGITS-1:0] slot_mask;
  logic [NUM_DIGITS-1:0] seen_next;
  logic [3:0]            dec_hex;
  logic                  dec_err;

  sseg_decoder u_decoder (
    .seg (seg_sync[6:0]),
    .hex (dec_hex),
    .err (dec_err)
  );

  always_comb begin
    bus_stable = ({an_sync, seg_sync} == {an_prev, seg_prev});
    an_changed = (an_sync != an_prev);
    slot_valid = 1'b1;
    slot_idx   = '0;
    case (an_sync)
      4'b1110: slot_idx = 2'd0;
      4'b1101: slot_idx = 2'd1;
      4'b1011: slot_idx = 2'd2;
      4'b0111: slot_idx = 2'd3;
      default: slot_valid = 1'b0;
    endcase
    // Requiring the bus to still match the previous sample keeps a change
    // arriving right as the counter saturates from being latched.
    do_latch  = bus_stable && (stab_cnt == CNT_MAX) && slot_valid && !visited;
    slot_mask = do_latch ? (NUM_DIGITS'(1) << slot_idx) : '0;
    seen_next = seen | slot_mask;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an_meta     <= 4'hF;
      an_sync     <= 4'hF;
      an_prev     <= 4'hF;
      seg_meta    <= {1'b1, GLYPH_BLANK};
      seg_sync    <= {1'b1, GLYPH_BLANK};
      seg_prev    <= {1'b1, GLYPH_BLANK};
      stab_cnt    <= '0;
      visited     <= 1'b0;
      seen        <= '0;
      frame_pend  <= 1'b0;
      tmo_cnt     <= '0;
      digits      <= '0;
      dp          <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_tick  <= 1'b0;
      // NOTE: the shadows are reset too, because a frame completed after a
      // partial post-reset scan must not expose digits from before the reset.
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      seg_meta <= seg;
      seg_sync <= seg_meta;
      an_prev  <= an_sync;
      seg_prev <= seg_sync;

      if (!bus_stable) stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + 1'b1;

      if (an_changed) visited <= 1'b0;
      else if (do_latch) visited <= 1'b1;

      if (do_latch) shadow[slot_idx] <= '{hex: dec_hex, dp: ~seg_sync[7], err: dec_err};

      if (do_latch && (seen_next == '1)) begin
        seen       <= '0;
        frame_pend <= 1'b1;
      end else begin
        seen       <= seen_next;
        frame_pend <= 1'b0;
      end

      // A pending frame takes priority over an expiring timeout.
      frame_tick <= 1'b0;
      if (frame_pend) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          digits[4*i +: 4] <= shadow[i].hex;
          dp[i]            <= shadow[i].dp;
          digit_err[i]     <= shadow[i].err;
        end
        frame_tick  <= 1'b1;
        frame_valid <= 1'b1;
        tmo_cnt     <= '0;
      end else if (frame_valid) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == '1) frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed and randomized bench for sseg_capture; random anode visits are
// scored against a visit-level model of which frames the receiver must emit.
module tb_sseg_capture;

  localparam int STABLE = 4;
  localparam int TW     = 8;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t obs_q[$];
  frame_t exp_q[$];

  sseg_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_W     (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_tick) obs_q.push_back('{digits: digits, dp: dp, err: digit_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    an    = 4'hF;
    seg   = 8'hFF;
    step(3);
    reset = 1'b1;
    obs_q.delete();
  endtask

  task automatic visit(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    step(n);
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] hex, input logic dp_on);
    return {~dp_on, GLYPH[hex]};
  endfunction

  function automatic logic [3:0] an_of(input int slot);
    logic [3:0] sel;
    sel = 4'b0001 << slot;
    return ~sel;
  endfunction

  task automatic scan4(input logic [15:0] hexes, input logic [3:0] dps, input int hold);
    for (int i = 0; i < 4; i++) visit(an_of(i), seg_of(hexes[4*i +: 4], dps[i]), hold);
  endtask

  // Returns {err, hex} for a raw glyph.
  function automatic logic [4:0] ref_decode(input logic [6:0] g);
    for (int h = 0; h < 16; h++) if (GLYPH[h] == g) return {1'b0, 4'(h)};
    return 5'b10000;
  endfunction

  initial begin
    int waited;
    int fall;
    logic [3:0] prev_an;
    logic [3:0] a;
    logic [7:0] s;
    int hold;
    int slot;
    logic [3:0] m_hex [4];
    logic [3:0] m_dp;
    logic [3:0] m_err;
    logic [3:0] m_seen;
    logic [4:0] dec;
    frame_t f;
    frame_t o;

    // Reset state, sampled while reset is still asserted.
    reset = 1'b0;
    step(3);
    check("rst_digits", digits, 16'h0);
    check("rst_dp", dp, 4'h0);
    check("rst_err", digit_err, 4'h0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_tick", frame_tick, 1'b0);

    // Clean scan of 1,2,3,4.
    do_reset();
    scan4(16'h4321, 4'b0000, 16);
    visit(4'hF, 8'hFF, 10);
    check("t1_ticks", obs_q.size(), 1);
    check("t1_digits", digits, 16'h4321);
    check("t1_dp", dp, 4'h0);
    check("t1_err", digit_err, 4'h0);
    check("t1_valid", frame_valid, 1'b1);

    // Slot 1 visited too briefly on the first pass.
    do_reset();
    visit(an_of(0), seg_of(4'h1, 1'b0), 16);
    visit(an_of(1), seg_of(4'h2, 1'b0), 3);
    visit(an_of(2), seg_of(4'h3, 1'b0), 16);
    visit(an_of(3), seg_of(4'h4, 1'b0), 16);
    check("t2_no_tick_first", obs_q.size(), 0);
    scan4(16'h4321, 4'b0000, 16);
    visit(4'hF, 8'hFF, 10);
    check("t2_ticks", obs_q.size(), 1);
    check("t2_digits", digits, 16'h4321);

    // Blank glyph on slot 2 is an error digit.
    do_reset();
    visit(an_of(0), seg_of(4'h5, 1'b0), 16);
    visit(an_of(1), seg_of(4'h5, 1'b0), 16);
    visit(an_of(2), 8'hFF, 16);
    visit(an_of(3), seg_of(4'h5, 1'b0), 16);
    visit(4'hF, 8'hFF, 10);
    check("t3_ticks", obs_q.size(), 1);
    check("t3_digits", digits, 16'h5055);
    check("t3_err", digit_err, 4'b0100);

    // Decimal point on slot 1 with A,b,C,d.
    do_reset();
    scan4(16'hDCBA, 4'b0010, 16);
    visit(4'hF, 8'hFF, 10);
    check("t4_dp", dp, 4'b0010);
    check("t4_digits", digits, 16'hDCBA);

    // Frame timeout after 2^TW cycles of an idle bus.
    do_reset();
    visit(an_of(0), seg_of(4'h7, 1'b0), 16);
    visit(an_of(1), seg_of(4'h8, 1'b0), 16);
    visit(an_of(2), seg_of(4'h9, 1'b0), 16);
    an  = an_of(3);
    seg = seg_of(4'hE, 1'b0);
    waited = 0;
    while (!frame_tick && waited < 40) begin
      step(1);
      waited++;
    end
    check("t5_tick_seen", frame_tick, 1'b1);
    check("t5_valid_at_tick", frame_valid, 1'b1);
    an  = 4'hF;
    seg = 8'hFF;
    fall = 0;
    while (frame_valid && fall < 300) begin
      step(1);
      fall++;
    end
    check("t5_fall_cycle", fall, 1 << TW);
    check("t5_digits_hold", digits, 16'hE987);

    // Reset in mid-frame discards the partial scan.
    do_reset();
    visit(an_of(0), seg_of(4'h1, 1'b0), 16);
    visit(an_of(1), seg_of(4'h2, 1'b0), 16);
    visit(an_of(2), seg_of(4'h3, 1'b0), 16);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    visit(an_of(3), seg_of(4'h4, 1'b0), 16);
    visit(4'hF, 8'hFF, 10);
    check("t6_no_tick", obs_q.size(), 0);
    check("t6_digits_zero", digits, 16'h0);
    check("t6_valid_zero", frame_valid, 1'b0);
    scan4(16'h4321, 4'b0000, 16);
    visit(4'hF, 8'hFF, 10);
    check("t6_tick_after", obs_q.size(), 1);

    // Random visits against the visit-level model.
    do_reset();
    exp_q.delete();
    prev_an = 4'hF;
    m_seen  = '0;
    m_dp    = '0;
    m_err   = '0;
    for (int i = 0; i < 4; i++) m_hex[i] = '0;
    for (int v = 0; v < 80; v++) begin
      do begin
        case ($urandom_range(0, 9))
          6:       a = 4'hF;
          7:       a = 4'h0;
          8, 9:    a = 4'($urandom());
          default: a = an_of($urandom_range(0, 3));
        endcase
      end while (a == prev_an);
      if ($urandom_range(0, 9) < 7) s[6:0] = GLYPH[$urandom_range(0, 15)];
      else s[6:0] = 7'($urandom());
      s[7] = 1'($urandom());
      hold = $urandom_range(1, 10);
      visit(a, s, hold);
      prev_an = a;
      if ($countones(~a) == 1 && hold >= STABLE + 1) begin
        slot = 0;
        for (int b = 0; b < 4; b++) if (!a[b]) slot = b;
        dec = ref_decode(s[6:0]);
        m_hex[slot] = dec[3:0];
        m_err[slot] = dec[4];
        m_dp[slot]  = ~s[7];
        m_seen[slot] = 1'b1;
        if (m_seen == 4'hF) begin
          f.digits = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
          f.dp     = m_dp;
          f.err    = m_err;
          exp_q.push_back(f);
          m_seen = '0;
        end
      end
    end
    visit(4'hF, 8'hFF, 20);
    check("rnd_frame_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      check($sformatf("rnd_digits[%0d]", i), o.digits, exp_q[i].digits);
      check($sformatf("rnd_dp[%0d]", i), o.dp, exp_q[i].dp);
      check($sformatf("rnd_err[%0d]", i), o.err, exp_q[i].err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receiving end of the multiplexed seven-segment interface driven by the display multiplexer. Samples the scanned `an`/`seg` lines, waits for each anode slot to be stable, decodes the glyph back to a hex digit, and publishes a coherent four-digit frame once every digit has been seen. Used for board-to-board loopback of the BCD stopwatch display and as a self-checking monitor in benches and on hardware.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a slot is latched (≥2).
- `TIMEOUT_W`, 20: width of the frame-timeout counter; `frame_valid` drops after 2^TIMEOUT_W cycles without a frame.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `an` in 4: anode enables, active-low, one-hot-low when valid; `an[i]` selects digit i.
- `seg` in 8: `seg[7]` = dp, `seg[6:0]` = {a,b,c,d,e,f,g}; all active-low.
- `digits` out 16: {d3,d2,d1,d0}, hex value per slot.
- `dp` out 4: decimal point per slot, 1 = lit.
- `digit_err` out 4: slot held a pattern that is not one of the 16 hex glyphs.
- `frame_valid` out 1: a frame has completed within the last 2^TIMEOUT_W cycles.
- `frame_tick` out 1: one-cycle pulse when `digits`/`dp`/`digit_err` update.

## Operation
- Two-flop synchronizer on `an` and `seg`; reset value `an`=4'hF, `seg`=8'hFF.
- Stability counter: cleared whenever the synchronized {an,seg} differs from the previous cycle; saturates at STABLE_CYCLES-1.
- Latch condition: counter reaches STABLE_CYCLES-1, synchronized `an` is one-hot-low, and the visit-latched flag is clear. The flag is set on latch and cleared when `an` changes. Each anode visit therefore latches at most once.
- On latch into slot i: decoded hex, `~seg[7]`, and error bit are written to slot shadow registers; `seen[i]` is set. A repeated visit to slot i before the frame completes overwrites the shadow; `seen` is unchanged.
- Non-one-hot `an` (4'hF, 4'h0, two or more low): never latched, no error flagged.
- Decode: glyph table identical to the display encoder. 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. Any other pattern gives hex 0 and err 1.
- Frame: when `seen` would become 4'b1111 (including the latching slot), on the next edge the shadows copy to the outputs, `frame_tick`=1, `frame_valid`=1, `seen` clears, and the timeout counter clears.
- Timeout counter increments every cycle while `frame_valid`=1. At all-ones, `frame_valid`←0. Outputs hold their last values.
- Frame completion and timeout expiry in the same cycle: the frame wins.
- Reset (any time, including mid-frame): all outputs 0, `seen`=0, shadows 0, counters 0, flags clear.

## Timing
- An input change sampled at edge k appears synchronized at k+2. The latch occurs at edge k+2+STABLE_CYCLES-1 if the input is held.
- `frame_tick` and the updated outputs appear one cycle after the fourth latch.
- Minimum per-anode hold time for capture: STABLE_CYCLES+1 cycles.
- Outputs change only on `frame_tick` cycles or on reset. `frame_valid` falls without a tick.

## Structure
- Package `sseg_pkg`: `NUM_DIGITS`=4, the 16 glyph constants, the blank pattern 7'h7F, and the slot/digit typedefs.
- Sub-module `sseg_decoder`: combinational seg[6:0] → {hex[3:0], err}, driven from the package table. Instantiated once on the synchronized bus.
- Everything else (synchronizer, stability filter, slot shadows, frame/timeout logic) lives in the top.

## Test plan
- Scan an=1110/1101/1011/0111 with glyphs 1,2,3,4, 16 cycles each, STABLE_CYCLES=4 → one `frame_tick`, `digits`=16'h4321, `dp`=0, `digit_err`=0, `frame_valid`=1.
- Same scan with the an=1101 slot held only 3 cycles before a second full scan → no tick during the first pass; tick after the second pass completes slot 1, `digits`=16'h4321.
- Glyph 1111111 on an=1011 and 0x5 elsewhere → `digits`=16'h5055, `digit_err`=4'b0100.
- seg[7]=0 on an=1101 with glyphs A,b,C,d → `dp`=4'b0010, `digits`=16'hDCBA.
- Complete one frame, then hold an=1111 for 2^TIMEOUT_W cycles (TIMEOUT_W=8) → `frame_valid` falls at cycle 256 after the tick, `digits` unchanged.
- Latch 3 slots, pulse `reset` low one cycle, then scan only slot 3 → no tick and outputs remain 0. A following full scan yields a tick.
